// File: rtl/alu_exec_pipe.sv
// Two-stage execute pipeline behind the ALU controller: S1 captures the operation,
// S2 holds the computed result, zero flag and tag until downstream takes it.
module alu_exec_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;
  logic             slt_bit;

  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !flush && (!s1_valid || s2_free);
  assign accept    = in_valid && in_ready;
  assign consume   = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign slt_bit   = $signed(s1_a) < $signed(s1_b);

  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (s1_op)
      OP_AND:  alu_result = s1_a & s1_b;
      OP_OR:   alu_result = s1_a | s1_b;
      OP_ADD:  alu_result = s1_a + s1_b;
      OP_SUB:  alu_result = s1_a - s1_b;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOR:  alu_result = ~(s1_a | s1_b);
      default: alu_illegal = 1'b1;
    endcase
  end

  // Flush empties both stages; an accept and an advance out of S1 may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op  <= in_op;
      s1_a   <= in_a;
      s1_b   <= in_b;
      s1_tag <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s1_adv) begin
        s2_valid <= 1'b1;
      end else if (consume) begin
        s2_valid <= 1'b0;
      end
      if (s1_adv) begin
        out_result  <= alu_result;
        out_zero    <= (alu_result == '0);
        out_illegal <= alu_illegal;
        out_tag     <= s1_tag;
      end
    end
  end

  // A result taken in the flush cycle is still counted as consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_count    <= '0;
      illegal_count <= '0;
    end else if (consume) begin
      done_count <= done_count + CNT_ONE;
      if (out_illegal) begin
        illegal_count <= illegal_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Bench for alu_exec_pipe: directed cases then random traffic, scored against a
// queue of expected results; a second copy with 2-bit counters checks wrap.
module tb_alu_exec_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;

  logic        in_ready, out_valid, out_zero, out_illegal;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [15:0] done_count, illegal_count;

  logic        w_in_ready, w_out_valid, w_out_zero, w_out_illegal;
  logic [31:0] w_out_result;
  logic [4:0]  w_out_tag;
  logic [1:0]  w_done_count, w_illegal_count;

  exp_t        q[$];
  bit          fresh;
  int          done_n, ill_n;
  int          total, bad;
  bit          acc;
  logic [3:0]  op_tab [8];

  alu_exec_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .out_tag(out_tag),
    .done_count(done_count), .illegal_count(illegal_count)
  );

  alu_exec_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(2)) u_wrap (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_result(w_out_result),
    .out_zero(w_out_zero), .out_illegal(w_out_illegal), .out_tag(w_out_tag),
    .done_count(w_done_count), .illegal_count(w_illegal_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] tag);
    exp_t e;
    e.illegal = 1'b0;
    e.tag     = tag;
    case (op)
      4'b0000: e.result = a & b;
      4'b0001: e.result = a | b;
      4'b0010: e.result = a + b;
      4'b0110: e.result = a - b;
      4'b0111: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: e.result = ~(a | b);
      default: begin e.result = 32'd0; e.illegal = 1'b1; end
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Only the oldest in-flight op can be in S2; a single op accepted on the last edge is still in S1.
  function automatic bit exp_valid();
    return (q.size() == 2) || (q.size() == 1 && !fresh);
  endfunction

  function automatic bit exp_ready();
    return !flush && (q.size() < 2 || out_ready);
  endfunction

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("in_ready", in_ready, exp_ready());
    cmp("out_valid", out_valid, exp_valid());
    cmp("w_in_ready", w_in_ready, exp_ready());
    cmp("w_out_valid", w_out_valid, exp_valid());
    if (exp_valid()) begin
      cmp("out_result", out_result, q[0].result);
      cmp("out_zero", out_zero, q[0].zero);
      cmp("out_illegal", out_illegal, q[0].illegal);
      cmp("out_tag", out_tag, q[0].tag);
      cmp("w_out_result", w_out_result, q[0].result);
    end
    cmp("done_count", done_count, done_n % 65536);
    cmp("illegal_count", illegal_count, ill_n % 65536);
    cmp("w_done_count", w_done_count, done_n % 4);
    cmp("w_illegal_count", w_illegal_count, ill_n % 4);
  endtask

  task automatic applyStimulus(input bit v, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag, input bit ordy,
                               input bit fl, output bit accepted);
    bit cons;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    #1;
    checkOutput();
    accepted = v && exp_ready();
    cons     = exp_valid() && ordy;
    @(posedge clk);
    if (cons) begin
      if (q[0].illegal) ill_n++;
      done_n++;
      void'(q.pop_front());
    end
    if (fl) begin
      q.delete();
      fresh = 1'b0;
    end else begin
      if (accepted) q.push_back(ref_op(op, a, b, tag));
      fresh = accepted;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input bit ordy);
    bit a_flag;
    applyStimulus(1'b1, op, a, b, tag, ordy, 1'b0, a_flag);
  endtask

  task automatic idle(input bit ordy);
    bit a_flag;
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, ordy, 1'b0, a_flag);
  endtask

  task automatic doReset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    q.delete();
    fresh  = 1'b0;
    done_n = 0;
    ill_n  = 0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    op_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010, 4'b1111};
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    @(negedge clk);
    doReset();
    cmp("rst_result", out_result, 32'd0);
    cmp("rst_zero", out_zero, 1'b0);
    cmp("rst_illegal", out_illegal, 1'b0);
    cmp("rst_tag", out_tag, 5'd0);

    send(4'b0010, 32'd7, 32'd5, 5'd3, 1'b1);
    idle(1'b1);
    cmp("add_result", out_result, 32'd12);
    cmp("add_zero", out_zero, 1'b0);
    cmp("add_tag", out_tag, 5'd3);
    idle(1'b1);
    cmp("add_done", done_count, 16'd1);

    send(4'b0110, 32'd5, 32'd5, 5'd1, 1'b1);
    idle(1'b1);
    cmp("sub_zero", out_zero, 1'b1);
    send(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1);
    idle(1'b1);
    cmp("slt_neg", out_result, 32'd1);
    send(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd3, 1'b1);
    idle(1'b1);
    cmp("slt_pos", out_result, 32'd0);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
    idle(1'b1);
    cmp("add_wrap", out_result, 32'd0);
    cmp("add_wrap_zero", out_zero, 1'b1);
    idle(1'b1);

    send(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5, 1'b1);
    send(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 1'b1);
    cmp("stream_and", out_result, 32'h00F0_00F0);
    send(4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd7, 1'b1);
    cmp("stream_or", out_result, 32'hFFF0_FFF0);
    idle(1'b1);
    cmp("stream_nor", out_result, 32'h000F_000F);
    idle(1'b1);

    send(4'b0010, 32'd100, 32'd23, 5'd8, 1'b0);
    send(4'b0001, 32'd1, 32'd2, 5'd9, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 4'b0110, 32'd9, 32'd4, 5'd10, 1'b0, 1'b0, acc);
      cmp("bp_in_ready", in_ready, 1'b0);
      cmp("bp_hold", out_result, 32'd123);
    end
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      applyStimulus(1'b1, 4'b0110, 32'd9, 32'd4, 5'd10, 1'b1, 1'b0, acc);
    end
    cmp("bp_accepted", acc, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    cmp("bp_drained", done_count, 16'd11);

    send(4'b1010, 32'd3, 32'd4, 5'd11, 1'b1);
    idle(1'b1);
    cmp("ill_flag", out_illegal, 1'b1);
    cmp("ill_result", out_result, 32'd0);
    idle(1'b1);
    cmp("ill_count", illegal_count, 16'd1);
    send(4'b0010, 32'd1, 32'd1, 5'd12, 1'b0);
    send(4'b0001, 32'd1, 32'd1, 5'd13, 1'b0);
    applyStimulus(1'b1, 4'b0010, 32'd2, 32'd2, 5'd14, 1'b0, 1'b1, acc);
    cmp("flush_valid", out_valid, 1'b0);
    cmp("flush_ill_count", illegal_count, 16'd1);
    idle(1'b1);

    send(4'b0010, 32'd5, 32'd6, 5'd15, 1'b0);
    send(4'b0010, 32'd7, 32'd8, 5'd16, 1'b0);
    doReset();
    idle(1'b0);
    cmp("rst_mid_done", done_count, 16'd0);

    for (int i = 0; i < 5; i++) send(4'b0001, i, 32'd0, 5'(i), 1'b1);
    idle(1'b1);
    idle(1'b1);
    cmp("wrap_done", w_done_count, 2'd1);
    cmp("wrap_full_done", done_count, 16'd5);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, op_tab[$urandom_range(0, 7)], rand_operand(),
                    rand_operand(), 5'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 29) == 0, acc);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
